// File: rtl/spi_reg_writer_pkg.sv
// rtl/spi_reg_writer_pkg.sv - shared state type, frame layout and frame builder for spi_reg_writer
package spi_reg_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_TAIL,
        ST_GAP
    } spi_wr_state_t;

    localparam int   FRAME_W   = 16;
    localparam int   ADDR_W    = 7;
    localparam int   DATA_W    = 8;
    localparam logic WRITE_BIT = 1'b1;

    localparam int RW_IDX   = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_LSB = 0;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] d
    );
        logic [FRAME_W-1:0] f;
        f                    = '0;
        f[RW_IDX]            = rw;
        f[ADDR_LSB +: ADDR_W] = a;
        f[DATA_LSB +: DATA_W] = d;
        return f;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - CLK_DIV phase down-counter; expire is high while the count is zero
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
    // Reloading CLK_DIV-1 makes each phase last exactly CLK_DIV cycles including the expire cycle.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/spi_reg_writer.sv
// rtl/spi_reg_writer.sv - SPI mode-0 register-write frame generator; SPI_REG_WRITER_READ_EN adds read frames
module spi_reg_writer
    import spi_reg_writer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef SPI_REG_WRITER_READ_EN
    input  logic              rw,
    input  logic              cipo,
    output logic [DATA_W-1:0] rdata,
`endif
    output logic              ready,
    output logic              done,
    output logic              ncs,
    output logic              sclk,
    output logic              copi
);

    localparam int               BCNT_W   = $clog2(FRAME_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W);

    spi_wr_state_t      state, state_d;
    logic [FRAME_W-1:0] shreg, shreg_d;
    logic [BCNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic               tmr_load, expire;
    logic               ncs_d, sclk_d, copi_d, done_d;
    logic               frame_rw;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expire (expire)
    );

    assign ready = (state == ST_IDLE);

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        tmr_load  = 1'b0;
        done_d    = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                shreg_d   = build_frame(frame_rw, addr, wdata);
                bit_cnt_d = '0;
                tmr_load  = 1'b1;
                state_d   = ST_SETUP;
            end
            ST_SETUP: if (expire) begin
                tmr_load = 1'b1;
                state_d  = ST_HIGH;
            end
            ST_HIGH: if (expire) begin
                tmr_load  = 1'b1;
                bit_cnt_d = bit_cnt + BCNT_W'(1);
                if (bit_cnt_d == LAST_BIT) begin
                    state_d = ST_TAIL;
                end else begin
                    shreg_d = {shreg[FRAME_W-2:0], 1'b0};
                    state_d = ST_LOW;
                end
            end
            ST_LOW: if (expire) begin
                tmr_load = 1'b1;
                state_d  = ST_HIGH;
            end
            ST_TAIL: if (expire) begin
                tmr_load = 1'b1;
                state_d  = ST_GAP;
            end
            ST_GAP: if (expire) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values are derived from the next state so they register on the same edge as the FSM.
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        case (state_d)
            ST_SETUP, ST_LOW: begin
                ncs_d  = 1'b0;
                copi_d = shreg_d[FRAME_W-1];
            end
            ST_HIGH: begin
                ncs_d  = 1'b0;
                sclk_d = 1'b1;
                copi_d = shreg_d[FRAME_W-1];
            end
            ST_TAIL: ncs_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ncs     <= 1'b1;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            ncs     <= ncs_d;
            sclk    <= sclk_d;
            copi    <= copi_d;
            done    <= done_d;
        end
    end

`ifdef SPI_REG_WRITER_READ_EN
    logic [DATA_W-1:0] rx_shreg;

    assign frame_rw = rw;

    // A LOW phase with bit_cnt 8..15 precedes rising edges 9..16, the data half of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shreg <= '0;
            rdata    <= '0;
        end else begin
            if (state == ST_LOW && expire && bit_cnt >= BCNT_W'(FRAME_W - DATA_W)) begin
                rx_shreg <= {rx_shreg[DATA_W-2:0], cipo};
            end
            if (state == ST_GAP && expire) begin
                rdata <= rx_shreg;
            end
        end
    end
`else
    assign frame_rw = WRITE_BIT;
`endif

endmodule
